// File: rtl/axi2mem_pipe_if.sv
// rtl/axi2mem_pipe_if.sv - AXI4 bus interface (AW, W, B, AR, R) with Master/Slave modports
//
// Ports: none; parameterised by AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_USER_WIDTH = 10
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/axi2mem_pipe.sv
// rtl/axi2mem_pipe.sv - AXI4 slave to pipelined SRAM-style memory bridge, one burst at a time
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   slave          AXI_BUS.Slave - AW/W/B/AR/R channels
//   req_o/gnt_i    memory request / grant (accepted when both high)
//   we_o, addr_o, be_o, data_o, user_o - memory write side, addr_o word aligned
//   data_i, user_i - read data, valid MEM_LATENCY cycles after acceptance
module axi2mem_pipe #(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 10,
  parameter int MEM_LATENCY    = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  AXI_BUS.Slave                       slave,
  output logic                        req_o,
  input  logic                        gnt_i,
  output logic                        we_o,
  output logic [AXI_ADDR_WIDTH-1:0]   addr_o,
  output logic [AXI_DATA_WIDTH/8-1:0] be_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_o,
  output logic [AXI_USER_WIDTH-1:0]   user_o,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  input  logic [AXI_USER_WIDTH-1:0]   user_i
);
  localparam int NB    = AXI_DATA_WIDTH / 8;
  localparam int LNB   = $clog2(NB);
  localparam int LW    = LNB + 1;
  localparam int DEPTH = MEM_LATENCY + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = AXI_ADDR_WIDTH;
  localparam logic [1:0] B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, SEND_B} state_t;

  state_t                    r_state;
  logic                      r_last_was_write, r_granted, r_rd_done;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AW-1:0]             r_addr;
  logic [7:0]                r_len, r_beat;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic [MEM_LATENCY-1:0]    r_vpipe, r_lpipe;
  logic [AXI_DATA_WIDTH-1:0] r_fifo_data [DEPTH];
  logic [AXI_USER_WIDTH-1:0] r_fifo_user [DEPTH];
  logic                      r_fifo_last [DEPTH];
  logic [PW-1:0]             r_wptr, r_rptr;
  logic [CW-1:0]             r_count;

  logic                      w_pick_rd, w_pick_wr, w_rd_issue, w_rd_accept, w_wr_hs;
  logic                      w_cap, w_pop, w_credit;
  logic [3:0]                w_inflight, w_outstanding;
  logic [7:0]                w_ax_len;
  logic [2:0]                w_ax_size;
  logic [1:0]                w_ax_burst, w_eff_burst;
  logic [AW-1:0]             w_off, w_size_mask, w_wrap_mask, w_beat_addr;
  logic [LW-1:0]             w_lane_lo, w_lane_hi, w_step;
  logic [NB-1:0]             w_lane;

  // Arbitration: a tie goes to the channel not granted last; before any grant, to the read.
  assign w_pick_rd = (r_state == IDLE) && !rst_i && slave.ar_valid &&
                     (!slave.aw_valid || !r_granted || r_last_was_write);
  assign w_pick_wr = (r_state == IDLE) && !rst_i && slave.aw_valid && !w_pick_rd;

  always_comb begin
    w_ax_len   = w_pick_rd ? slave.ar_len   : slave.aw_len;
    w_ax_size  = w_pick_rd ? slave.ar_size  : slave.aw_size;
    w_ax_burst = w_pick_rd ? slave.ar_burst : slave.aw_burst;
    if (w_ax_size > 3'(LNB)) w_ax_size = 3'(LNB);
    w_eff_burst = w_ax_burst;
    if (w_ax_burst == 2'b11) w_eff_burst = B_INCR;
    else if (w_ax_burst == B_WRAP && !(w_ax_len inside {8'd1, 8'd3, 8'd7, 8'd15})) w_eff_burst = B_INCR;
  end

  // Beat address; wrap length is a power of two so the modulo is a mask.
  always_comb begin
    w_off       = AW'(r_beat) << r_size;
    w_size_mask = (AW'(1) << r_size) - AW'(1);
    w_wrap_mask = ((AW'(r_len) + AW'(1)) << r_size) - AW'(1);
    case (r_burst)
      B_FIXED: w_beat_addr = r_addr;
      B_WRAP:  w_beat_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_off) & w_wrap_mask);
      default: w_beat_addr = (r_beat == 8'd0) ? r_addr : (r_addr & ~w_size_mask) + w_off;
    endcase
  end

  // Active lanes: from the beat's byte offset up to the next size-aligned boundary.
  always_comb begin
    w_step    = LW'(1) << r_size;
    w_lane_lo = {1'b0, w_beat_addr[LNB-1:0]};
    w_lane_hi = (w_lane_lo & ~(w_step - LW'(1))) + w_step;
    for (int i = 0; i < NB; i++) w_lane[i] = (LW'(i) >= w_lane_lo) && (LW'(i) < w_lane_hi);
  end

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) w_inflight = w_inflight + 4'(r_vpipe[i]);
  end

  // A beat leaving the FIFO this cycle frees its slot for a new request.
  assign w_pop         = (r_state == READ) && (r_count != '0) && slave.r_ready;
  assign w_outstanding = w_inflight + 4'(r_count) - 4'(w_pop);
  assign w_credit      = w_outstanding < 4'(DEPTH);
  assign w_rd_issue    = (r_state == READ) && !r_rd_done && w_credit;
  assign w_rd_accept   = w_rd_issue && gnt_i;
  assign w_wr_hs       = (r_state == WRITE) && slave.w_valid && gnt_i;
  assign w_cap         = r_vpipe[MEM_LATENCY-1];

  always_comb begin
    req_o          = 1'b0;
    we_o           = 1'b0;
    be_o           = '0;
    addr_o         = w_beat_addr & ~AW'(NB - 1);
    data_o         = slave.w_data;
    user_o         = slave.w_user;
    if (r_state == WRITE) begin
      req_o = slave.w_valid;
      we_o  = 1'b1;
      be_o  = slave.w_strb & w_lane;
    end else if (r_state == READ) begin
      req_o = w_rd_issue;
      be_o  = w_rd_issue ? w_lane : '0;
    end
  end

  assign slave.ar_ready = w_pick_rd;
  assign slave.aw_ready = w_pick_wr;
  assign slave.w_ready  = (r_state == WRITE) && gnt_i;
  assign slave.b_valid  = (r_state == SEND_B);
  assign slave.b_id     = r_id;
  assign slave.b_resp   = 2'b00;
  assign slave.b_user   = r_user;
  assign slave.r_valid  = (r_state == READ) && (r_count != '0);
  assign slave.r_id     = r_id;
  assign slave.r_resp   = 2'b00;
  assign slave.r_data   = r_fifo_data[r_rptr];
  assign slave.r_user   = r_fifo_user[r_rptr];
  assign slave.r_last   = r_fifo_last[r_rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state          <= IDLE;
      r_last_was_write <= 1'b0;
      r_granted        <= 1'b0;
      r_rd_done        <= 1'b0;
      r_id             <= '0;
      r_addr           <= '0;
      r_len            <= '0;
      r_beat           <= '0;
      r_size           <= '0;
      r_burst          <= '0;
      r_user           <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_pick_rd || w_pick_wr) begin
          r_id             <= w_pick_rd ? slave.ar_id   : slave.aw_id;
          r_addr           <= w_pick_rd ? slave.ar_addr : slave.aw_addr;
          r_user           <= w_pick_rd ? slave.ar_user : slave.aw_user;
          r_len            <= w_ax_len;
          r_size           <= w_ax_size;
          r_burst          <= w_eff_burst;
          r_beat           <= '0;
          r_rd_done        <= 1'b0;
          r_granted        <= 1'b1;
          r_last_was_write <= w_pick_wr;
          r_state          <= w_pick_rd ? READ : WRITE;
        end
        READ: begin
          if (w_rd_accept) begin
            if (r_beat == r_len) r_rd_done <= 1'b1;
            else                 r_beat    <= r_beat + 8'd1;
          end
          if (w_pop && r_fifo_last[r_rptr]) r_state <= IDLE;
        end
        WRITE: if (w_wr_hs) begin
          r_beat <= r_beat + 8'd1;
          if (slave.w_last) r_state <= SEND_B;
        end
        SEND_B: if (slave.b_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Valid/last shift pipe and FIFO pointers; cleared on reset so pre-reset responses vanish.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vpipe <= '0;
      r_lpipe <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_vpipe <= MEM_LATENCY'({r_vpipe, w_rd_accept});
      r_lpipe <= MEM_LATENCY'({r_lpipe, (r_beat == r_len)});
      if (w_cap) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      r_count <= r_count + CW'(w_cap) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_cap) begin
      r_fifo_data[r_wptr] <= data_i;
      r_fifo_user[r_wptr] <= user_i;
      r_fifo_last[r_wptr] <= r_lpipe[MEM_LATENCY-1];
    end
  end
endmodule

// File: tb/tb_axi2mem_pipe.sv
// tb/tb_axi2mem_pipe.sv - directed self-checking bench for axi2mem_pipe (64-bit data, latency 2)
module tb_axi2mem_pipe;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        gnt_i = 1'b1;
  logic        req_o, we_o;
  logic [63:0] addr_o, data_o;
  logic [7:0]  be_o;
  logic [9:0]  user_o;
  logic [63:0] data_i = '0;
  logic [9:0]  user_i = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)) bus ();

  axi2mem_pipe #(.AXI_ID_WIDTH(10), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
                 .AXI_USER_WIDTH(10), .MEM_LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .slave(bus), .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o),
    .addr_o(addr_o), .be_o(be_o), .data_o(data_o), .user_o(user_o), .data_i(data_i), .user_i(user_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [63:0] rd_data(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  function automatic logic [9:0] rd_user(input logic [63:0] a);
    return a[12:3] ^ 10'h2AA;
  endfunction

  // Memory model: read accepted in cycle t returns data during cycle t+2.
  logic        mp_v = 0, m0_v = 0, m1_v = 0;
  logic [63:0] mp_a = 0, m0_a = 0, m1_a = 0;
  always @(negedge clk) if (!rst_i && req_o && gnt_i && !we_o) begin mp_v = 1; mp_a = addr_o; end
  always @(posedge clk) begin
    #1;
    m1_v = m0_v; m1_a = m0_a;
    m0_v = mp_v; m0_a = mp_a;
    mp_v = 0;
    data_i = m1_v ? rd_data(m1_a) : 64'h0BAD_0BAD_0BAD_0BAD;
    user_i = m1_v ? rd_user(m1_a) : 10'h3FF;
  end

  // Transaction logs, sampled mid-cycle.
  logic [63:0] acc_addr[$], acc_data[$], r_data_q[$];
  logic [7:0]  acc_be[$];
  logic        acc_we[$], r_last_q[$];
  logic [9:0]  r_id_q[$], b_id_q[$];
  logic [1:0]  b_resp_q[$];
  int          acc_cyc[$], r_cyc_q[$], grant_q[$];

  always @(negedge clk) if (!rst_i) begin
    if (req_o && gnt_i) begin
      acc_addr.push_back(addr_o); acc_be.push_back(be_o); acc_we.push_back(we_o);
      acc_data.push_back(data_o); acc_cyc.push_back(cyc);
    end
    if (bus.r_valid && bus.r_ready) begin
      r_data_q.push_back(bus.r_data); r_last_q.push_back(bus.r_last);
      r_id_q.push_back(bus.r_id); r_cyc_q.push_back(cyc);
    end
    if (bus.b_valid && bus.b_ready) begin b_id_q.push_back(bus.b_id); b_resp_q.push_back(bus.b_resp); end
    if (bus.ar_valid && bus.ar_ready) grant_q.push_back(0);
    if (bus.aw_valid && bus.aw_ready) grant_q.push_back(1);
  end

  function automatic logic [63:0] q64(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction
  function automatic logic [7:0] q8(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction
  function automatic logic q1(input logic q[$], input int i);
    return (i < q.size()) ? q[i] : 1'bx;
  endfunction
  function automatic logic [9:0] q10(input logic [9:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction

  task automatic clear_logs();
    acc_addr.delete(); acc_data.delete(); acc_be.delete(); acc_we.delete(); acc_cyc.delete();
    r_data_q.delete(); r_last_q.delete(); r_id_q.delete(); r_cyc_q.delete();
    b_id_q.delete(); b_resp_q.delete(); grant_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_i = 1;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
  endtask

  task automatic send_ar(input logic [9:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    bus.ar_id = id; bus.ar_addr = a; bus.ar_len = len; bus.ar_size = size;
    bus.ar_burst = burst; bus.ar_user = 10'h011; bus.ar_valid = 1;
    do begin @(negedge clk); n++; end while (!bus.ar_ready && n < 50);
    checks++;
    if (!bus.ar_ready) begin errors++; $display("FAIL ar_handshake: ar_ready=%0b required 1", bus.ar_ready); end
    @(posedge clk); #1 bus.ar_valid = 0;
  endtask

  task automatic send_aw(input logic [9:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    bus.aw_id = id; bus.aw_addr = a; bus.aw_len = len; bus.aw_size = size;
    bus.aw_burst = burst; bus.aw_user = 10'h022; bus.aw_valid = 1;
    do begin @(negedge clk); n++; end while (!bus.aw_ready && n < 50);
    checks++;
    if (!bus.aw_ready) begin errors++; $display("FAIL aw_handshake: aw_ready=%0b required 1", bus.aw_ready); end
    @(posedge clk); #1 bus.aw_valid = 0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
    int n = 0;
    bus.w_data = d; bus.w_strb = strb; bus.w_last = last; bus.w_user = 10'h033; bus.w_valid = 1;
    do begin @(negedge clk); n++; end while (!bus.w_ready && n < 50);
    checks++;
    if (!bus.w_ready) begin errors++; $display("FAIL w_handshake: w_ready=%0b required 1", bus.w_ready); end
    @(posedge clk); #1 bus.w_valid = 0;
  endtask

  task automatic wait_r(input int n, input int budget);
    int k = 0;
    while (r_data_q.size() < n && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (r_data_q.size() < n) begin errors++; $display("FAIL r_timeout: beats=%0d required %0d", r_data_q.size(), n); end
  endtask

  task automatic test_reset();
    bus.ar_valid = 1; bus.aw_valid = 1;
    #1;
    checks++;
    if ({req_o, we_o, bus.ar_ready, bus.aw_ready, bus.w_ready, bus.r_valid, bus.b_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: req/we/ar_rdy/aw_rdy/w_rdy/r_vld/b_vld=%b required 0000000",
               {req_o, we_o, bus.ar_ready, bus.aw_ready, bus.w_ready, bus.r_valid, bus.b_valid});
    end
    bus.ar_valid = 0; bus.aw_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
  endtask

  task automatic test_incr_read();
    clear_logs();
    send_ar(10'h2A5, 64'h100, 8'd3, 3'd3, 2'b01);
    wait_r(4, 60);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] ea = 64'h100 + 64'(i * 8);
      checks++; if (q64(acc_addr, i) !== ea) begin errors++; $display("FAIL rd_addr%0d: %h required %h", i, q64(acc_addr, i), ea); end
      checks++; if (q64(r_data_q, i) !== rd_data(ea)) begin errors++; $display("FAIL rd_data%0d: %h required %h", i, q64(r_data_q, i), rd_data(ea)); end
      checks++; if (q1(r_last_q, i) !== (i == 3)) begin errors++; $display("FAIL rd_last%0d: %b required %b", i, q1(r_last_q, i), i == 3); end
      checks++; if (q10(r_id_q, i) !== 10'h2A5) begin errors++; $display("FAIL rd_id%0d: %h required 2a5", i, q10(r_id_q, i)); end
    end
    if (acc_cyc.size() > 0 && r_cyc_q.size() > 3) begin
      checks++; if (r_cyc_q[0] - acc_cyc[0] !== 3) begin errors++; $display("FAIL rd_latency: %0d required 3", r_cyc_q[0] - acc_cyc[0]); end
      checks++; if (r_cyc_q[3] - r_cyc_q[0] !== 3) begin errors++; $display("FAIL rd_throughput: %0d required 3", r_cyc_q[3] - r_cyc_q[0]); end
    end
  endtask

  task automatic test_wrap_write();
    logic [63:0] ea [4] = '{64'h118, 64'h100, 64'h108, 64'h110};
    int k = 0;
    clear_logs();
    send_aw(10'h1C3, 64'h118, 8'd3, 3'd3, 2'b10);
    for (int i = 0; i < 4; i++) send_w(64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF, i == 3);
    while (b_id_q.size() < 1 && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 4; i++) begin
      checks++; if (q64(acc_addr, i) !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d: %h required %h", i, q64(acc_addr, i), ea[i]); end
      checks++; if (q64(acc_data, i) !== 64'hC0DE_0000_0000_0000 + 64'(i)) begin errors++; $display("FAIL wrap_data%0d: %h", i, q64(acc_data, i)); end
      checks++; if ({q1(acc_we, i), q8(acc_be, i)} !== 9'h1FF) begin errors++; $display("FAIL wrap_we_be%0d: %h required 1ff", i, {q1(acc_we, i), q8(acc_be, i)}); end
    end
    repeat (3) @(negedge clk);
    checks++; if (b_id_q.size() !== 1) begin errors++; $display("FAIL wrap_bcount: %0d required 1", b_id_q.size()); end
    checks++; if (q10(b_id_q, 0) !== 10'h1C3) begin errors++; $display("FAIL wrap_bid: %h required 1c3", q10(b_id_q, 0)); end
    checks++; if (b_resp_q.size() > 0 && b_resp_q[0] !== 2'b00) begin errors++; $display("FAIL wrap_bresp: %b required 00", b_resp_q[0]); end
  endtask

  task automatic test_narrow_write();
    logic [7:0] eb [3] = '{8'h08, 8'h30, 8'hC0};
    clear_logs();
    send_aw(10'h044, 64'h103, 8'd2, 3'd1, 2'b01);
    for (int i = 0; i < 3; i++) send_w(64'h5555_AAAA_0000_0000 + 64'(i), 8'hFF, i == 2);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (q64(acc_addr, i) !== 64'h100) begin errors++; $display("FAIL narrow_addr%0d: %h required 100", i, q64(acc_addr, i)); end
      checks++; if (q8(acc_be, i) !== eb[i]) begin errors++; $display("FAIL narrow_be%0d: %h required %h", i, q8(acc_be, i), eb[i]); end
    end
    checks++; if (b_id_q.size() !== 1) begin errors++; $display("FAIL narrow_bcount: %0d required 1", b_id_q.size()); end
  endtask

  task automatic test_boundary();
    clear_logs();
    send_ar(10'h077, 64'h505, 8'd1, 3'd7, 2'b11);
    wait_r(2, 40);
    send_ar(10'h078, 64'h610, 8'd2, 3'd3, 2'b10);
    wait_r(5, 40);
    checks++; if (q64(acc_addr, 0) !== 64'h500 || q8(acc_be, 0) !== 8'hE0) begin errors++; $display("FAIL clamp_beat0: %h/%h required 500/e0", q64(acc_addr, 0), q8(acc_be, 0)); end
    checks++; if (q64(acc_addr, 1) !== 64'h508 || q8(acc_be, 1) !== 8'hFF) begin errors++; $display("FAIL clamp_beat1: %h/%h required 508/ff", q64(acc_addr, 1), q8(acc_be, 1)); end
    checks++; if (q64(r_data_q, 1) !== rd_data(64'h508)) begin errors++; $display("FAIL clamp_rdata: %h required %h", q64(r_data_q, 1), rd_data(64'h508)); end
    for (int i = 0; i < 3; i++) begin
      logic [63:0] ea = 64'h610 + 64'(i * 8);
      checks++; if (q64(acc_addr, i + 2) !== ea) begin errors++; $display("FAIL badwrap_addr%0d: %h required %h", i, q64(acc_addr, i + 2), ea); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held_d;
    logic        held_l;
    clear_logs();
    bus.r_ready = 0;
    send_ar(10'h0AB, 64'h200, 8'd7, 3'd3, 2'b01);
    repeat (20) @(negedge clk);
    checks++; if (acc_addr.size() > 3) begin errors++; $display("FAIL bp_accepts: %0d required <=3", acc_addr.size()); end
    checks++; if (bus.r_valid !== 1'b1) begin errors++; $display("FAIL bp_rvalid: %b required 1", bus.r_valid); end
    held_d = bus.r_data; held_l = bus.r_last;
    repeat (3) @(negedge clk);
    checks++; if ({bus.r_data, bus.r_last} !== {held_d, held_l}) begin errors++; $display("FAIL bp_stable: %h required %h", bus.r_data, held_d); end
    @(posedge clk); #1 bus.r_ready = 1;
    wait_r(8, 80);
    for (int i = 0; i < 8; i++) begin
      logic [63:0] ea = 64'h200 + 64'(i * 8);
      checks++; if (q64(r_data_q, i) !== rd_data(ea)) begin errors++; $display("FAIL bp_data%0d: %h required %h", i, q64(r_data_q, i), rd_data(ea)); end
    end
    checks++; if (q1(r_last_q, 7) !== 1'b1 || q1(r_last_q, 6) !== 1'b0) begin errors++; $display("FAIL bp_last: %b%b required 10", q1(r_last_q, 7), q1(r_last_q, 6)); end
    checks++; if (acc_addr.size() !== 8) begin errors++; $display("FAIL bp_total: %0d required 8", acc_addr.size()); end
  endtask

  task automatic test_contention();
    int k = 0;
    do_reset();
    clear_logs();
    @(posedge clk); #1;
    bus.ar_id = 10'h001; bus.ar_addr = 64'h700; bus.ar_len = 0; bus.ar_size = 3; bus.ar_burst = 1; bus.ar_valid = 1;
    bus.aw_id = 10'h002; bus.aw_addr = 64'h800; bus.aw_len = 0; bus.aw_size = 3; bus.aw_burst = 1; bus.aw_valid = 1;
    bus.w_data = 64'h1; bus.w_strb = 8'hFF; bus.w_last = 1; bus.w_valid = 1;
    while (grant_q.size() < 4 && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1 bus.ar_valid = 0; bus.aw_valid = 0;
    repeat (10) @(posedge clk);
    #1 bus.w_valid = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      int g = (i < grant_q.size()) ? grant_q[i] : -1;
      checks++; if (g !== i % 2) begin errors++; $display("FAIL arb_grant%0d: %0d required %0d", i, g, i % 2); end
    end
  endtask

  task automatic test_reset_mid_read();
    clear_logs();
    send_ar(10'h055, 64'h300, 8'd7, 3'd3, 2'b01);
    wait_r(2, 40);
    #2 rst_i = 1;
    #1;
    checks++; if ({req_o, bus.r_valid, bus.ar_ready} !== 3'b000) begin errors++; $display("FAIL rst_mid: req/r_vld/ar_rdy=%b required 000", {req_o, bus.r_valid, bus.ar_ready}); end
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    clear_logs();
    repeat (10) @(negedge clk);
    checks++; if (r_data_q.size() + acc_addr.size() !== 0) begin errors++; $display("FAIL rst_stale: %0d beats/reqs required 0", r_data_q.size() + acc_addr.size()); end
    send_ar(10'h066, 64'h400, 8'd1, 3'd3, 2'b01);
    wait_r(2, 40);
    repeat (5) @(negedge clk);
    checks++; if (r_data_q.size() !== 2) begin errors++; $display("FAIL rst_next_count: %0d required 2", r_data_q.size()); end
    for (int i = 0; i < 2; i++) begin
      logic [63:0] ea = 64'h400 + 64'(i * 8);
      checks++; if (q64(r_data_q, i) !== rd_data(ea)) begin errors++; $display("FAIL rst_next_data%0d: %h required %h", i, q64(r_data_q, i), rd_data(ea)); end
    end
    checks++; if (q10(r_id_q, 1) !== 10'h066 || q1(r_last_q, 1) !== 1'b1) begin errors++; $display("FAIL rst_next_idlast: %h/%b required 066/1", q10(r_id_q, 1), q1(r_last_q, 1)); end
  endtask

  initial begin
    bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0; bus.aw_user = 0; bus.aw_valid = 0;
    bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.w_user = 0; bus.w_valid = 0;
    bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0; bus.ar_user = 0; bus.ar_valid = 0;
    bus.b_ready = 1; bus.r_ready = 1;
    test_reset();
    test_incr_read();
    test_wrap_write();
    test_narrow_write();
    test_boundary();
    test_backpressure();
    test_contention();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
